// File: rtl/spec_fifo_pkg.sv
// Shared defaults and pointer helpers for the speculative-commit FIFO.
package spec_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 9;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_AF_MARGIN  = 1024;
    localparam int CNT_W          = 16;

    // Occupancy between two lap-bit pointers; the caller keeps ADDR_WIDTH+1 LSBs,
    // which makes the subtraction wrap correctly.
    function automatic logic [31:0] ptr_level(logic [31:0] head, logic [31:0] tail);
        return head - tail;
    endfunction

endpackage

// File: rtl/spec_fifo_sync_if.sv
// Write/commit/read bundle of spec_fifo_sync; master drives requests, slave is the FIFO.
interface spec_fifo_sync_if
    import spec_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  writeEn;
    logic                  commitWrite;
    logic                  rollbackWrite;
    logic                  full;
    logic                  almostFull;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   specLevel;
    logic [ADDR_WIDTH:0]   level;
    logic                  readEn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  empty;
    logic                  notEmpty;
    logic [CNT_W-1:0]      commitCnt;
    logic [CNT_W-1:0]      rollbackCnt;

    modport master (
        output dataIn, writeEn, commitWrite, rollbackWrite, readEn,
        input  full, almostFull, overflow, specLevel, level, dataOut,
               empty, notEmpty, commitCnt, rollbackCnt
    );

    modport slave (
        input  dataIn, writeEn, commitWrite, rollbackWrite, readEn,
        output full, almostFull, overflow, specLevel, level, dataOut,
               empty, notEmpty, commitCnt, rollbackCnt
    );
endinterface

// File: rtl/spec_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module spec_fifo_ram #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/spec_fifo_sync.sv
// Speculative-write FIFO with commit/rollback and a FWFT read side.
// Optional statistics counters are built when SPEC_FIFO_STATS_EN is defined.
module spec_fifo_sync
    import spec_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_MARGIN  = DEF_AF_MARGIN
) (
    input  logic            clk,
    input  logic            reset,
    spec_fifo_sync_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] AF_TH   = DEPTH_P - PW'(AF_MARGIN);

    logic [PW-1:0] wrPtr_q, wrPtr_d, comPtr_q, comPtr_d, rdPtr_q, rdPtr_d;
    logic [PW-1:0] fePtr_q, fePtr_d;
    logic [PW-1:0] specLevel_q, specLevel_d, level_q, level_d;
    logic          full_q, almostFull_q, overflow_q;
    logic          ram_vld_q, out_vld_q;
    logic [DATA_WIDTH-1:0] dout_q, ram_rdata;
    logic          eff_rb, wr_acc, wr_drop, pop, ram_to_out, fetch;
    logic [31:0]   spec_diff, com_diff;
    logic          unused_diff;

    // fePtr trails comPtr and walks committed words into the RAM read register
    always_comb begin
        eff_rb      = bus.rollbackWrite && !bus.commitWrite;
        wr_acc      = bus.writeEn && !full_q && !eff_rb;
        wr_drop     = bus.writeEn && full_q && !eff_rb;
        pop         = bus.readEn && out_vld_q;
        ram_to_out  = ram_vld_q && (!out_vld_q || pop);
        fetch       = (fePtr_q != comPtr_q) && (!ram_vld_q || ram_to_out);
        wrPtr_d     = eff_rb ? comPtr_q : wrPtr_q + PW'(wr_acc);
        comPtr_d    = bus.commitWrite ? wrPtr_d : comPtr_q;
        rdPtr_d     = rdPtr_q + PW'(pop);
        fePtr_d     = fePtr_q + PW'(fetch);
        spec_diff   = ptr_level(32'(wrPtr_d), 32'(rdPtr_d));
        com_diff    = ptr_level(32'(comPtr_d), 32'(rdPtr_d));
        specLevel_d = spec_diff[PW-1:0];
        level_d     = com_diff[PW-1:0];
    end

    assign unused_diff = ^{spec_diff[31:PW], com_diff[31:PW]};

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q      <= '0;
            comPtr_q     <= '0;
            rdPtr_q      <= '0;
            fePtr_q      <= '0;
            specLevel_q  <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            almostFull_q <= 1'b0;
            overflow_q   <= 1'b0;
            ram_vld_q    <= 1'b0;
            out_vld_q    <= 1'b0;
            dout_q       <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            comPtr_q     <= comPtr_d;
            rdPtr_q      <= rdPtr_d;
            fePtr_q      <= fePtr_d;
            specLevel_q  <= specLevel_d;
            level_q      <= level_d;
            full_q       <= (specLevel_d == DEPTH_P);
            almostFull_q <= (specLevel_d >= AF_TH);
            overflow_q   <= overflow_q || wr_drop;
            ram_vld_q    <= fetch || (ram_vld_q && !ram_to_out);
            out_vld_q    <= ram_to_out || (out_vld_q && !pop);
            if (ram_to_out) dout_q <= ram_rdata;
        end
    end

    spec_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (wr_acc),
        .waddr_i(wrPtr_q[ADDR_WIDTH-1:0]),
        .wdata_i(bus.dataIn),
        .re_i   (fetch),
        .raddr_i(fePtr_q[ADDR_WIDTH-1:0]),
        .rdata_o(ram_rdata)
    );

    assign bus.full       = full_q;
    assign bus.almostFull = almostFull_q;
    assign bus.overflow   = overflow_q;
    assign bus.specLevel  = specLevel_q;
    assign bus.level      = level_q;
    assign bus.dataOut    = dout_q;
    assign bus.empty      = !out_vld_q;
    assign bus.notEmpty   = out_vld_q;

`ifdef SPEC_FIFO_STATS_EN
    logic [CNT_W-1:0] ccnt_q, rcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ccnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            if (bus.commitWrite && ccnt_q != '1) ccnt_q <= ccnt_q + 1'b1;
            if (eff_rb && rcnt_q != '1)          rcnt_q <= rcnt_q + 1'b1;
        end
    end

    assign bus.commitCnt   = ccnt_q;
    assign bus.rollbackCnt = rcnt_q;
`else
    assign bus.commitCnt   = '0;
    assign bus.rollbackCnt = '0;
`endif
endmodule

// File: tb/tb_spec_fifo_sync.sv
// Directed bench for spec_fifo_sync: commit/rollback, FWFT timing, fill/overflow, streaming, reset.
module tb_spec_fifo_sync;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    int exp_cc = 0;
    int exp_rc = 0;

`ifdef SPEC_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    spec_fifo_sync_if #(.DATA_WIDTH(9), .ADDR_WIDTH(12)) bus ();

    spec_fifo_sync #(.DATA_WIDTH(9), .ADDR_WIDTH(12), .AF_MARGIN(1024)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_exp(int v);
        int s;
        s = (v > 65535) ? 65535 : v;
        return 32'(s) & {32{STATS}};
    endfunction

    task automatic idle_in();
        bus.writeEn = 1'b0;
        bus.commitWrite = 1'b0;
        bus.rollbackWrite = 1'b0;
        bus.readEn = 1'b0;
        bus.dataIn = '0;
    endtask

    task automatic chk_reset_state();
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_af", 32'(bus.almostFull), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_speclvl", 32'(bus.specLevel), 0);
        chk("rst_lvl", 32'(bus.level), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_notempty", 32'(bus.notEmpty), 0);
        chk("rst_dout", 32'(bus.dataOut), 0);
        chk("rst_ccnt", 32'(bus.commitCnt), 0);
        chk("rst_rcnt", 32'(bus.rollbackCnt), 0);
    endtask

    task automatic write_word(logic [8:0] d);
        bus.writeEn = 1'b1;
        bus.dataIn = d;
        tick();
        bus.writeEn = 1'b0;
    endtask

    // Bounded wait for the head, then check and pop it.
    task automatic pop_expect(string tag, logic [8:0] exp);
        int n = 0;
        while (!bus.notEmpty && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.dataOut), 32'(exp));
        bus.readEn = 1'b1;
        tick();
        bus.readEn = 1'b0;
    endtask

    initial begin
        int wr_seq, rd_seq, cyc, bad;
        idle_in();
        reset = 1'b1;
        tick();
        tick();
        chk_reset_state();
        reset = 1'b0;

        // three uncommitted words stay invisible to the reader
        for (int i = 0; i < 3; i++) write_word(9'(32'h101 + i));
        tick();
        tick();
        chk("spec_notempty", 32'(bus.notEmpty), 0);
        chk("spec_speclvl", 32'(bus.specLevel), 3);
        chk("spec_lvl", 32'(bus.level), 0);

        // commit at edge N, head visible from N+2, back-to-back pops
        bus.commitWrite = 1'b1;
        tick();
        exp_cc++;
        bus.commitWrite = 1'b0;
        chk("com_lvl_n", 32'(bus.level), 3);
        chk("com_ne_n", 32'(bus.notEmpty), 0);
        tick();
        chk("com_ne_n1", 32'(bus.notEmpty), 0);
        tick();
        chk("com_ne_n2", 32'(bus.notEmpty), 1);
        chk("com_dout_n2", 32'(bus.dataOut), 32'h101);
        bus.readEn = 1'b1;
        tick();
        chk("b2b_dout1", 32'(bus.dataOut), 32'h102);
        tick();
        chk("b2b_dout2", 32'(bus.dataOut), 32'h103);
        tick();
        chk("b2b_empty", 32'(bus.empty), 1);
        tick();
        bus.readEn = 1'b0;
        chk("rd_empty_lvl", 32'(bus.level), 0);
        chk("rd_empty_e", 32'(bus.empty), 1);

        // commit 5, then roll back 4 speculative words
        for (int i = 0; i < 5; i++) write_word(9'(32'h1A0 + i));
        bus.commitWrite = 1'b1;
        tick();
        exp_cc++;
        bus.commitWrite = 1'b0;
        for (int i = 0; i < 4; i++) write_word(9'(32'h0F0 + i));
        bus.rollbackWrite = 1'b1;
        bus.writeEn = 1'b1;
        bus.dataIn = 9'h1FF;
        tick();
        exp_rc++;
        idle_in();
        chk("rb_speclvl", 32'(bus.specLevel), 5);
        chk("rb_lvl", 32'(bus.level), 5);
        chk("rb_ovf", 32'(bus.overflow), 0);
        for (int i = 0; i < 5; i++) pop_expect("rb_data", 9'(32'h1A0 + i));
        tick();
        tick();
        chk("rb_drained", 32'(bus.empty), 1);
        chk("rb_drained_sl", 32'(bus.specLevel), 0);

        // commit and rollback together: commit wins, same-cycle word included
        write_word(9'h0C0);
        write_word(9'h0C1);
        bus.writeEn = 1'b1;
        bus.dataIn = 9'h0C2;
        bus.commitWrite = 1'b1;
        bus.rollbackWrite = 1'b1;
        tick();
        exp_cc++;
        idle_in();
        chk("cw_lvl", 32'(bus.level), 3);
        chk("cw_speclvl", 32'(bus.specLevel), 3);
        for (int i = 0; i < 3; i++) pop_expect("cw_data", 9'(32'h0C0 + i));
        chk("cw_ccnt", 32'(bus.commitCnt), cnt_exp(exp_cc));
        chk("cw_rcnt", 32'(bus.rollbackCnt), cnt_exp(exp_rc));

        // fill to DEPTH, almostFull threshold, then overflow
        bus.writeEn = 1'b1;
        for (int k = 1; k <= 4096; k++) begin
            bus.dataIn = 9'(k);
            tick();
            if (k == 3071) chk("af_below", 32'(bus.almostFull), 0);
            if (k == 3072) chk("af_at", 32'(bus.almostFull), 1);
            if (k == 4095) chk("full_below", 32'(bus.full), 0);
        end
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_af", 32'(bus.almostFull), 1);
        chk("fill_speclvl", 32'(bus.specLevel), 4096);
        chk("fill_ovf0", 32'(bus.overflow), 0);
        tick();
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_speclvl", 32'(bus.specLevel), 4096);
        bus.rollbackWrite = 1'b1;
        tick();
        exp_rc++;
        idle_in();
        chk("fill_rb_sl", 32'(bus.specLevel), 0);
        chk("fill_rb_full", 32'(bus.full), 0);
        chk("ovf_sticky", 32'(bus.overflow), 1);
        chk("fill_ccnt", 32'(bus.commitCnt), cnt_exp(exp_cc));
        chk("fill_rcnt", 32'(bus.rollbackCnt), cnt_exp(exp_rc));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cc = 0;
        exp_rc = 0;
        chk("ovf_cleared", 32'(bus.overflow), 0);

        // stream with write, read and commit every cycle across many wraps
        wr_seq = 0;
        rd_seq = 0;
        cyc = 0;
        bad = 0;
        while (rd_seq < 10000 && cyc < 15000) begin
            bus.readEn = bus.notEmpty;
            if (bus.notEmpty) begin
                if (bus.dataOut !== 9'(rd_seq)) bad++;
                rd_seq++;
            end
            bus.writeEn = (wr_seq < 10000);
            bus.dataIn = 9'(wr_seq);
            bus.commitWrite = 1'b1;
            exp_cc++;
            tick();
            if (wr_seq < 10000) wr_seq++;
            cyc++;
        end
        idle_in();
        chk("stream_bad", 32'(bad), 0);
        chk("stream_cnt", 32'(rd_seq), 10000);
        chk("stream_lvl", 32'(bus.level), 0);
        chk("stream_ccnt", 32'(bus.commitCnt), cnt_exp(exp_cc));

        // reset mid-stream with every input active
        for (int i = 0; i < 40; i++) begin
            bus.readEn = bus.notEmpty;
            bus.writeEn = 1'b1;
            bus.dataIn = 9'(i);
            bus.commitWrite = 1'b1;
            tick();
        end
        bus.readEn = 1'b1;
        reset = 1'b1;
        tick();
        chk_reset_state();
        reset = 1'b0;
        idle_in();
        tick();
        tick();
        chk("post_rst_ne", 32'(bus.notEmpty), 0);
        chk("post_rst_lvl", 32'(bus.level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
